// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and load sequencer for one shared WIDTH-bit enabled register.
// Four requesters use a four-phase req/gnt handshake; each grant loads the register once.
module shared_reg_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   d_bus,
    output logic [3:0]           gnt,
    output logic [3:0]           ack,
    output logic [WIDTH-1:0]     q,
    output logic [1:0]           owner,
    output logic                 busy,
    output logic [7:0]           load_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [1:0]         r_ptr, w_ptr_nxt;
    logic [1:0]         r_owner, w_owner_nxt;
    logic [3:0]         r_gnt, w_gnt_nxt;
    logic [3:0]         r_ack, w_ack_nxt;
    logic [WIDTH-1:0]   r_q, w_q_nxt;
    logic [7:0]         r_cnt, w_cnt_nxt;
    logic [1:0]         w_winner;
    logic [1:0]         w_idx;
    logic               w_found;

    // First requester found scanning upward from r_ptr, wrapping mod 4.
    always_comb begin
        w_winner = r_ptr;
        w_found  = 1'b0;
        w_idx    = r_ptr;
        for (int unsigned k = 0; k < 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_gnt_nxt   = r_gnt;
        w_ack_nxt   = '0;
        w_q_nxt     = r_q;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_LOAD;
                    w_owner_nxt = w_winner;
                    w_gnt_nxt   = 4'b0001 << w_winner;
                end
            end
            S_LOAD: begin
                // Register enable cycle: load happens even if req[owner] already dropped.
                w_q_nxt     = d_bus[r_owner*WIDTH +: WIDTH];
                w_ack_nxt   = 4'b0001 << r_owner;
                w_cnt_nxt   = r_cnt + 8'd1;
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (!req[r_owner]) begin
                    w_state_nxt = S_IDLE;
                    w_gnt_nxt   = '0;
                    w_ptr_nxt   = r_owner + 2'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ack   <= w_ack_nxt;
            r_q     <= w_q_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign gnt      = r_gnt;
    assign ack      = r_ack;
    assign q        = r_q;
    assign owner    = r_owner;
    assign busy     = (r_state != S_IDLE);
    assign load_cnt = r_cnt;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: directed handshake scenarios followed by
// randomized transactions checked against a transaction-level round-robin model.
module tb_shared_reg_arbiter;

    localparam int W = 8;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [3:0]         req;
    logic [4*W-1:0]     d_bus;
    logic [3:0]         gnt;
    logic [3:0]         ack;
    logic [W-1:0]       q;
    logic [1:0]         owner;
    logic               busy;
    logic [7:0]         load_cnt;

    int n_cmp = 0;
    int n_mis = 0;

    // Transaction-level reference: rotating priority start, load count, last loaded word.
    int         m_ptr;
    int         m_cnt;
    logic [W-1:0] m_q;

    shared_reg_arbiter #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .d_bus    (d_bus),
        .gnt      (gnt),
        .ack      (ack),
        .q        (q),
        .owner    (owner),
        .busy     (busy),
        .load_cnt (load_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] word_of(input logic [4*W-1:0] bus, input int i);
        return bus[i*W +: W];
    endfunction

    function automatic int model_pick(input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            if (r[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [31:0] onehot(input int i);
        return 32'(1) << i;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},   32'(gnt),      32'd0);
        chk({tag, "_ack"},   32'(ack),      32'd0);
        chk({tag, "_q"},     32'(q),        32'd0);
        chk({tag, "_owner"}, 32'(owner),    32'd0);
        chk({tag, "_cnt"},   32'(load_cnt), 32'd0);
        chk({tag, "_busy"},  32'(busy),     32'd0);
    endtask

    task automatic rand_bus();
        for (int i = 0; i < 4; i++) d_bus[i*W +: W] = W'($urandom);
    endtask

    task automatic rand_txn(input bit force_early);
        logic [3:0]   r;
        logic [W-1:0] qs;
        int           w;
        int           h;
        bit           early;
        r = 4'($urandom_range(1, 15));
        rand_bus();
        req = r;
        w = model_pick(r);
        tick();
        chk("rr_gnt",   32'(gnt),   onehot(w));
        chk("rr_owner", 32'(owner), 32'(w));
        chk("rr_busy",  32'(busy),  32'd1);
        chk("rr_ack0",  32'(ack),   32'd0);
        early = force_early || ($urandom_range(0, 3) == 0);
        qs = word_of(d_bus, w);
        if (early) req = 4'b0000;
        tick();
        m_cnt = (m_cnt + 1) % 256;
        m_q   = qs;
        chk("rr_q",    32'(q),        32'(m_q));
        chk("rr_ack",  32'(ack),      onehot(w));
        chk("rr_cnt",  32'(load_cnt), 32'(m_cnt));
        chk("rr_busy_hold", 32'(busy), 32'd1);
        if (!early) begin
            h = $urandom_range(0, 2);
            repeat (h) begin
                rand_bus();
                tick();
                chk("hold_q",   32'(q),   32'(m_q));
                chk("hold_ack", 32'(ack), 32'd0);
                chk("hold_gnt", 32'(gnt), onehot(w));
            end
            req = 4'b0000;
        end
        tick();
        chk("rel_gnt",  32'(gnt),  32'd0);
        chk("rel_busy", 32'(busy), 32'd0);
        chk("rel_ack",  32'(ack),  32'd0);
        chk("rel_q",    32'(q),    32'(m_q));
        m_ptr = (w + 1) % 4;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int ord [5];
        ord = '{0, 1, 2, 3, 0};

        // Reset values, then quiet for 5 cycles after release.
        reset_n = 1'b0;
        req     = 4'b0000;
        d_bus   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("rst");
        reset_n = 1'b1;
        repeat (5) begin
            tick();
            chk_all_zero("rst_idle");
        end

        // Single requester 2.
        d_bus = 32'h33A52211;
        req   = 4'b0100;
        tick();
        chk("single_gnt",   32'(gnt),   32'h4);
        chk("single_owner", 32'(owner), 32'd2);
        chk("single_busy",  32'(busy),  32'd1);
        cyc = 0;
        while (ack == 4'b0000 && cyc < 5) begin
            tick();
            cyc++;
        end
        chk("single_ack_lat", 32'(cyc),      32'd1);
        chk("single_q",       32'(q),        32'hA5);
        chk("single_ack",     32'(ack),      32'h4);
        chk("single_cnt",     32'(load_cnt), 32'd1);
        req = 4'b0000;
        tick();
        chk("single_gnt_off", 32'(gnt),  32'd0);
        chk("single_ack_off", 32'(ack),  32'd0);
        chk("single_busy0",   32'(busy), 32'd0);

        // Async reset while requester 1 is in LOAD.
        d_bus = 32'h00007700;
        req   = 4'b0010;
        tick();
        chk("rstld_gnt", 32'(gnt), 32'h2);
        reset_n = 1'b0;
        #1;
        chk_all_zero("rst_async");
        req = 4'b0000;
        @(posedge clk);
        #1;
        chk_all_zero("rst_hold");
        reset_n = 1'b1;

        // Round-robin fairness with all four requesting.
        d_bus = 32'h44332211;
        req   = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            cyc = 0;
            while (gnt == 4'b0000 && cyc < 8) begin
                tick();
                cyc++;
            end
            chk("fair_gnt",   32'(gnt),   onehot(ord[k]));
            chk("fair_owner", 32'(owner), 32'(ord[k]));
            tick();
            chk("fair_ack", 32'(ack), onehot(ord[k]));
            chk("fair_q",   32'(q),   32'(word_of(d_bus, ord[k])));
            req[ord[k]] = 1'b0;
            tick();
            chk("fair_rel", 32'(gnt), 32'd0);
            req[ord[k]] = 1'b1;
        end
        req = 4'b0000;

        // Data isolation: owner 3 in HOLD, bus changes, requester 1 waits.
        req = 4'b1000;
        tick();
        chk("iso_gnt", 32'(gnt), 32'h8);
        tick();
        chk("iso_q",   32'(q),   32'h44);
        chk("iso_ack", 32'(ack), 32'h8);
        d_bus = 32'hDEADBEEF;
        req   = 4'b1010;
        repeat (3) begin
            tick();
            chk("iso_hold_gnt", 32'(gnt),  32'h8);
            chk("iso_hold_q",   32'(q),    32'h44);
            chk("iso_hold_ack", 32'(ack),  32'd0);
            chk("iso_hold_bsy", 32'(busy), 32'd1);
        end
        req = 4'b0010;
        tick();
        chk("iso_rel", 32'(gnt), 32'd0);
        tick();
        chk("iso_next_gnt",   32'(gnt),   32'h2);
        chk("iso_next_owner", 32'(owner), 32'd1);
        tick();
        chk("iso_next_q",   32'(q),   32'hBE);
        chk("iso_next_ack", 32'(ack), 32'h2);
        req = 4'b0000;
        tick();
        chk("iso_done", 32'(gnt), 32'd0);

        // Fresh start for the randomized run so the counter wraps on the 256th load.
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        m_ptr = 0;
        m_cnt = 0;
        m_q   = '0;
        chk("rand_start_cnt", 32'(load_cnt), 32'd0);
        for (int n = 0; n < 256; n++) begin
            rand_txn(n == 0);
            if (n == 255) chk("cnt_wrap", 32'(load_cnt), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

Round-robin arbiter and load sequencer for one shared WIDTH-bit enabled D register, the same enabled-register primitive used throughout the latch/flip-flop lab. Four requesters compete for write access. The block grants one requester at a time using a four-phase req/gnt handshake. It drives the register's enable for exactly one cycle per grant, so the winner's data is captured, and it counts completed loads.

## Interface
- WIDTH, default 8, width of the shared register and of each requester's data word.

- clk  input  1  system clock; all state changes on rising edge
- reset_n  input  1  asynchronous, active-low reset
- req  input  4  request lines; req[i] belongs to requester i
- d_bus  input  4*WIDTH  requester data; d_bus[i*WIDTH +: WIDTH] is requester i's word
- gnt  output  4  registered one-hot grant; all zero when idle
- ack  output  4  one-cycle load-done pulse to the owner
- q  output  WIDTH  shared register contents
- owner  output  2  index of the current or last granted requester
- busy  output  1  high whenever state is not IDLE
- load_cnt  output  8  number of completed loads

## Operation
- States:
  - IDLE: gnt is 0. If any req bit is set, choose a winner round-robin starting at ptr, checking ptr, ptr+1, ptr+2, ptr+3 (mod 4). Next state is LOAD, owner takes the winner, gnt takes one-hot(winner).
  - LOAD: the internal enable is 1. At the edge, q takes the owner's word from d_bus, ack[owner] goes to 1 for one cycle, load_cnt increments, and the state moves to HOLD. This happens unconditionally, even if req[owner] has dropped.
  - HOLD: gnt is held and the register enable is 0. When req[owner] is 0, the next state is IDLE, gnt goes to 0, and ptr takes owner+1 (mod 4, so 3 wraps to 0). Otherwise the block stays in HOLD.
- q changes only in LOAD. In every other state it holds its value, even if d_bus changes.
- Requests from non-owners are ignored in LOAD and HOLD. They stay pending and are arbitrated in the next IDLE.
- load_cnt is 8-bit and wraps from 255 to 0.
- ack is never asserted outside the cycle that follows LOAD. At most one ack bit is high at a time.
- gnt has at most one bit set. When gnt is nonzero, gnt[owner] is the bit that is set.
- Reset (reset_n = 0) is asynchronous and takes effect immediately, including in the middle of a transaction:
  - state goes to IDLE and ptr to 0
  - gnt, ack, q, owner and load_cnt all go to 0, and busy goes to 0
  - any load in progress is abandoned and q is not written
- On release of reset, the block arbitrates at the first rising edge that sees reset_n = 1.

## Timing
- Request to grant: gnt is high after 1 edge, at the first edge where IDLE sees req.
- Grant to data: q and ack are valid after the next edge, 2 edges after the request is sampled.
- Release: after req[owner] falls, gnt falls at the next edge, and IDLE can grant again at the edge after that.
- Minimum transaction: 4 edges (IDLE→LOAD→HOLD→IDLE→next LOAD) when the requester drops req on the same cycle it sees ack.
- busy is decoded from the state register with no extra latency. All other outputs are registered.

## Test plan
- **Reset values:** hold reset_n = 0, then release, with req = 0. Required: gnt = 0, ack = 0, q = 0, owner = 0, load_cnt = 0, busy = 0, and nothing changes over 5 cycles.
- **Single requester:** WIDTH = 8, d_bus word 2 = 8'hA5, req = 4'b0100, drop req when ack is seen. Required:
  - gnt = 4'b0100 one edge after the request
  - q = 8'hA5 and ack = 4'b0100 for one cycle at the next edge
  - load_cnt = 1
  - gnt = 0 one edge after req drops
- **Round-robin fairness:** req = 4'b1111 held by all requesters, each one dropping on its own ack and re-raising one cycle later. Required grant order is 0, 1, 2, 3, 0, and q matches each winner's word.
- **Data isolation:** while in HOLD, change all d_bus words and raise req[1] alongside owner 3. Required: q is unchanged, and gnt stays 4'b1000 until req[3] drops, after which requester 1 is granted next (ptr = 0 after the wrap, 1 is the first requester found).
- **Early withdrawal:** owner drops req during LOAD. Required: q is still loaded, ack still pulses, and the block returns to IDLE one edge after HOLD.
- **Reset and counter wrap:** assert reset_n low while gnt = 4'b0010 in LOAD. Required: all outputs are 0 immediately, with no ack. Separately, run 256 single transactions; required load_cnt = 0 after the 256th.
